// File: rtl/map_read_arbiter.sv
// map_read_arbiter: round-robin share of one map BRAM read port among NUM_REQ DDA requesters.
// Latency: request seen in cycle 0 -> map_addr_out in cycle 1 -> data_valid_out in cycle 2+BRAM_LATENCY.
// Backpressure: none. Each requester has at most one read in flight and must take its data on the valid pulse.
module map_read_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int N            = 24,
  parameter int DATA_W       = 4,
  parameter int BRAM_LATENCY = 2,
  localparam int ADDR_W      = $clog2(N*N)
) (
  input  logic                      pixel_clk_in,
  input  logic                      rst_n_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  output logic [DATA_W-1:0]         data_out,
  output logic [NUM_REQ-1:0]        data_valid_out,
  output logic [ADDR_W-1:0]         map_addr_out,
  input  logic [DATA_W-1:0]         map_data_in,
  output logic                      busy_out
);

  localparam int ID_W = $clog2(NUM_REQ);

  // One tag per issued cycle: whether a read was issued and for whom.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0] pending;
  logic [ID_W-1:0]    last_grant;
  tag_t               tag_pipe [BRAM_LATENCY+1];

  logic [NUM_REQ-1:0] eligible;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  logic [ADDR_W-1:0]  grant_addr;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] exit_onehot;
  tag_t               tag_exit;

  // A requester whose previous read has not yet pulsed its valid cannot be granted again.
  assign eligible = req_in & ~pending;
  assign busy_out = |pending;
  assign tag_exit = tag_pipe[BRAM_LATENCY];

  // Round-robin pick: first eligible requester searching last_grant+1, +2, ... wrapping.
  // Both loops unroll to constants, so every index below is static.
  always_comb begin
    grant_vld    = 1'b0;
    grant_id     = '0;
    grant_addr   = '0;
    grant_onehot = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld && eligible[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
          grant_vld       = 1'b1;
          grant_id        = ID_W'(i);
          grant_addr      = addr_in[i*ADDR_W +: ADDR_W];
          grant_onehot[i] = 1'b1;
        end
      end
    end
  end

  // Decode the tag leaving the pipe into the per-requester valid pulse.
  always_comb begin
    exit_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_exit.vld && (tag_exit.id == ID_W'(i))) begin
        exit_onehot[i] = 1'b1;
      end
    end
  end

  // Tag pipe: stage 0 travels alongside map_addr_out, and stage BRAM_LATENCY
  // is present exactly in the cycle the BRAM presents that address's data.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s <= BRAM_LATENCY; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      tag_pipe[0].vld <= grant_vld;
      tag_pipe[0].id  <= grant_id;
      for (int s = 1; s <= BRAM_LATENCY; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  // Issue side, return side and per-requester in-flight bookkeeping.
  // pending clears at the end of the valid cycle, so a request seen during
  // that cycle is ignored and re-granted one cycle later.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      data_valid_out <= '0;
      data_out       <= '0;
      map_addr_out   <= '0;
      pending        <= '0;
      last_grant     <= ID_W'(NUM_REQ-1);
    end else begin
      data_valid_out <= exit_onehot;
      if (tag_exit.vld) begin
        data_out <= map_data_in;
      end
      if (grant_vld) begin
        map_addr_out <= grant_addr;
        last_grant   <= grant_id;
      end
      pending <= (pending & ~data_valid_out) | grant_onehot;
    end
  end

endmodule

// File: tb/tb_map_read_arbiter.sv
module tb_map_read_arbiter;

  localparam int N      = 24;
  localparam int ADDR_W = $clog2(N*N);
  localparam int DATA_W = 4;

  typedef struct packed {
    logic [1:0]        id;
    logic [DATA_W-1:0] dat;
  } exp_t;

  logic pixel_clk_in = 1'b0;
  always #5 pixel_clk_in = ~pixel_clk_in;
  logic rst_n_in;

  // Two-requester instance
  logic [1:0]          req2;
  logic [2*ADDR_W-1:0] addr2;
  logic [DATA_W-1:0]   dout2, mdata2, pipe2;
  logic [1:0]          dv2;
  logic [ADDR_W-1:0]   maddr2;
  logic                busy2;

  // Three-requester instance
  logic [2:0]          req3;
  logic [3*ADDR_W-1:0] addr3;
  logic [DATA_W-1:0]   dout3, mdata3, pipe3;
  logic [2:0]          dv3;
  logic [ADDR_W-1:0]   maddr3;
  logic                busy3;

  logic [DATA_W-1:0] mem [0:1023];
  exp_t q2[$];
  exp_t q3[$];
  exp_t e2, e3;
  int n_chk = 0;
  int n_fail = 0;
  int cnt2 [2] = '{0, 0};

  map_read_arbiter #(.NUM_REQ(2), .N(N), .DATA_W(DATA_W), .BRAM_LATENCY(2)) dut2 (
    .pixel_clk_in(pixel_clk_in), .rst_n_in(rst_n_in), .req_in(req2), .addr_in(addr2),
    .data_out(dout2), .data_valid_out(dv2), .map_addr_out(maddr2),
    .map_data_in(mdata2), .busy_out(busy2)
  );

  map_read_arbiter #(.NUM_REQ(3), .N(N), .DATA_W(DATA_W), .BRAM_LATENCY(2)) dut3 (
    .pixel_clk_in(pixel_clk_in), .rst_n_in(rst_n_in), .req_in(req3), .addr_in(addr3),
    .data_out(dout3), .data_valid_out(dv3), .map_addr_out(maddr3),
    .map_data_in(mdata3), .busy_out(busy3)
  );

  // Read-first BRAM models with two cycles from address to data.
  always @(posedge pixel_clk_in) begin
    pipe2  <= mem[maddr2];
    mdata2 <= pipe2;
    pipe3  <= mem[maddr3];
    mdata3 <= pipe3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push2(input int id, input int a);
    exp_t e;
    e.id  = 2'(id);
    e.dat = mem[a];
    q2.push_back(e);
  endtask

  task automatic push3(input int id, input int a);
    exp_t e;
    e.id  = 2'(id);
    e.dat = mem[a];
    q3.push_back(e);
  endtask

  // Scoreboard: every valid pulse must match the oldest expected read, both owner and data.
  always @(negedge pixel_clk_in) begin
    if (dv2 != 2'b00) begin
      chk("dv2_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        chk("dv2_owner", 32'(dv2), 32'(3'b001 << e2.id));
        chk("dout2", 32'(dout2), 32'(e2.dat));
        if (dv2[0]) cnt2[0]++;
        if (dv2[1]) cnt2[1]++;
      end
    end
    if (dv3 != 3'b000) begin
      chk("dv3_expected", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        e3 = q3.pop_front();
        chk("dv3_owner", 32'(dv3), 32'(4'b0001 << e3.id));
        chk("dout3", 32'(dout3), 32'(e3.dat));
      end
    end
  end

  initial begin
    int cyc;
    int a;
    int base0, base1;
    int issued [3];

    for (int i = 0; i < 1024; i++) mem[i] = DATA_W'(i*5 + i/16);
    mem[25] = 4'd3;
    rst_n_in = 1'b0;
    req2 = '0; addr2 = '0;
    req3 = '0; addr3 = '0;
    repeat (3) @(negedge pixel_clk_in);

    // Reset state
    chk("rst_dv2", 32'(dv2), 32'd0);
    chk("rst_dout2", 32'(dout2), 32'd0);
    chk("rst_maddr2", 32'(maddr2), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_dv3", 32'(dv3), 32'd0);

    // Simultaneous requests: requester 0 first, then 1
    rst_n_in = 1'b1;
    req2 = 2'b11;
    addr2[0 +: ADDR_W] = ADDR_W'(5);
    addr2[ADDR_W +: ADDR_W] = ADDR_W'(7);
    push2(0, 5); push2(1, 7);
    @(negedge pixel_clk_in);
    chk("t2_addr_c1", 32'(maddr2), 32'd5);
    chk("t2_busy_c1", 32'(busy2), 32'd1);
    @(negedge pixel_clk_in);
    chk("t2_addr_c2", 32'(maddr2), 32'd7);
    @(negedge pixel_clk_in);
    chk("t2_dv_c3", 32'(dv2), 32'd0);
    @(negedge pixel_clk_in);
    chk("t2_dv_c4", 32'(dv2), 32'b01);
    req2[0] = 1'b0;
    @(negedge pixel_clk_in);
    chk("t2_dv_c5", 32'(dv2), 32'b10);
    chk("t2_busy_c5", 32'(busy2), 32'd1);
    req2[1] = 1'b0;
    @(negedge pixel_clk_in);
    chk("t2_busy_c6", 32'(busy2), 32'd0);

    // Single request, address 25 holds cell value 3
    req2 = 2'b01;
    addr2[0 +: ADDR_W] = ADDR_W'(25);
    push2(0, 25);
    @(negedge pixel_clk_in);
    chk("t1_addr_c1", 32'(maddr2), 32'd25);
    for (int c = 2; c <= 3; c++) begin
      @(negedge pixel_clk_in);
      chk("t1_dv_early", 32'(dv2), 32'd0);
    end
    @(negedge pixel_clk_in);
    chk("t1_dv_c4", 32'(dv2), 32'b01);
    chk("t1_dout_c4", 32'(dout2), 32'd3);
    req2 = 2'b00;
    @(negedge pixel_clk_in);
    chk("t1_dv_c5", 32'(dv2), 32'd0);

    // Request held through its valid cycle; new out-of-range address re-granted one cycle later, then dropped early
    @(negedge pixel_clk_in);
    req2 = 2'b01;
    addr2[0 +: ADDR_W] = ADDR_W'(100);
    push2(0, 100);
    @(negedge pixel_clk_in);
    chk("t4_addr_c1", 32'(maddr2), 32'd100);
    repeat (3) @(negedge pixel_clk_in);
    chk("t4_dv_c4", 32'(dv2), 32'b01);
    addr2[0 +: ADDR_W] = ADDR_W'(1000);
    push2(0, 1000);
    @(negedge pixel_clk_in);
    chk("t4_no_regrant_c5", 32'(maddr2), 32'd100);
    @(negedge pixel_clk_in);
    chk("t4_regrant_c6", 32'(maddr2), 32'd1000);
    req2 = 2'b00;
    repeat (3) @(negedge pixel_clk_in);
    chk("t4_dv_c9", 32'(dv2), 32'b01);
    chk("t4_dout_c9", 32'(dout2), 32'(mem[1000]));
    @(negedge pixel_clk_in);
    chk("t4_dv_c10", 32'(dv2), 32'd0);
    chk("t4_busy_c10", 32'(busy2), 32'd0);

    // Reset one cycle after a grant discards the read
    req2 = 2'b01;
    addr2[0 +: ADDR_W] = ADDR_W'(300);
    @(negedge pixel_clk_in);
    chk("t5_addr_c1", 32'(maddr2), 32'd300);
    rst_n_in = 1'b0;
    req2 = 2'b00;
    @(negedge pixel_clk_in);
    chk("t5_rst_dv", 32'(dv2), 32'd0);
    chk("t5_rst_dout", 32'(dout2), 32'd0);
    chk("t5_rst_maddr", 32'(maddr2), 32'd0);
    chk("t5_rst_busy", 32'(busy2), 32'd0);
    rst_n_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge pixel_clk_in);
      chk("t5_no_valid", 32'(dv2), 32'd0);
    end

    // Both requesters continuously active for 100 reads; queue order enforces alternation
    base0 = cnt2[0];
    base1 = cnt2[1];
    issued = '{1, 1, 0};
    req2 = 2'b11;
    addr2[0 +: ADDR_W] = ADDR_W'(11);
    addr2[ADDR_W +: ADDR_W] = ADDR_W'(12);
    push2(0, 11); push2(1, 12);
    cyc = 0;
    while (q2.size() != 0 && cyc < 1000) begin
      @(negedge pixel_clk_in);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (dv2[i]) begin
          if (issued[i] < 50) begin
            a = int'($urandom_range(0, N*N-1));
            addr2[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
            push2(i, a);
            issued[i]++;
          end else begin
            req2[i] = 1'b0;
          end
        end
      end
    end
    chk("t3_timeout", 32'(cyc < 1000), 32'd1);
    chk("t3_total", 32'((cnt2[0] - base0) + (cnt2[1] - base1)), 32'd100);
    chk("t3_fair", 32'(((cnt2[0] - base0) - (cnt2[1] - base1)) <= 1 &&
                       ((cnt2[1] - base1) - (cnt2[0] - base0)) <= 1), 32'd1);

    // Three requesters from the same cycle: rotation 0,1,2,0,...
    @(negedge pixel_clk_in);
    issued = '{1, 1, 1};
    req3 = 3'b111;
    addr3[0 +: ADDR_W] = ADDR_W'(40);
    addr3[ADDR_W +: ADDR_W] = ADDR_W'(41);
    addr3[2*ADDR_W +: ADDR_W] = ADDR_W'(42);
    push3(0, 40); push3(1, 41); push3(2, 42);
    @(negedge pixel_clk_in);
    chk("t6_addr_c1", 32'(maddr3), 32'd40);
    @(negedge pixel_clk_in);
    chk("t6_addr_c2", 32'(maddr3), 32'd41);
    @(negedge pixel_clk_in);
    chk("t6_addr_c3", 32'(maddr3), 32'd42);
    chk("t6_busy_c3", 32'(busy3), 32'd1);
    cyc = 0;
    while (q3.size() != 0 && cyc < 1000) begin
      @(negedge pixel_clk_in);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (dv3[i]) begin
          if (issued[i] < 8) begin
            a = int'($urandom_range(0, N*N-1));
            addr3[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
            push3(i, a);
            issued[i]++;
          end else begin
            req3[i] = 1'b0;
          end
        end
      end
    end
    chk("t6_timeout", 32'(cyc < 1000), 32'd1);
    @(negedge pixel_clk_in);
    chk("t6_idle_busy", 32'(busy3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
